bin_to_bcd_seq: RTL
===================

// Module: bin_to_bcd_seq
// PURPOSE
//   Iterative (shift-add-3 / double-dabble) binary-to-BCD converter, parametrised
//   in input width and output digit count; one result bit resolved per clock.
//   Feeds the seven-segment / display-digit path wherever a wide binary value
//   (counter, score, timer) is shown in decimal. Start/busy/done handshake;
//   reports overflow when the value does not fit in DIGITS decimal digits.
// PARAMETERS
//   WIDTH   16  binary input width in bits (>=2)
//   DIGITS  5   number of BCD output digits (>=1); 4*DIGITS output bits
// PORTS
//   clk       in   1           system clock, all state on rising edge
//   rst       in   1           synchronous reset, active-high
//   start     in   1           request conversion of bin; sampled only when busy=0
//   bin       in   WIDTH       binary operand, captured on accepted start
//   busy      out  1           conversion in progress
//   done      out  1           one-cycle pulse: bcd/overflow updated this cycle
//   bcd       out  4*DIGITS    result, digit k = bcd[4k+3:4k], k=0 is units
//   overflow  out  1           1 = bin >= 10**DIGITS; bcd then holds bin mod 10**DIGITS
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, bcd=0, overflow=0; internal shift/count regs=0.
//   States: IDLE, SHIFT.
//   IDLE: edge with start=1 -> capture bin into shift reg, clear working BCD reg and
//     overflow accumulator, load count=WIDTH, busy<=1, go SHIFT. start=0 -> stay.
//   SHIFT, each edge:
//     - every working digit >=5 gets +3 (all digits corrected in parallel, pre-shift);
//     - {working BCD, shift reg} shifts left 1; bit leaving top of working BCD is
//       OR'd into overflow accumulator;
//     - count decrements.
//     On the edge where count goes 1->0: bcd<=final working BCD,
//       overflow<=accumulator, done<=1, busy<=0, go IDLE.
//   Latency: start sampled at edge E0 -> done high in cycle after edge E0+WIDTH;
//     busy high for exactly WIDTH cycles.
//   done is high for exactly one cycle; deasserts on the next edge unconditionally.
//   start while busy=1: ignored, no queuing, bin changes ignored.
//   start in the done cycle (busy=0): accepted; back-to-back rate 1 per WIDTH+1 cycles.
//   bcd and overflow hold last completed result until next completion or reset;
//     they never show partial values.
//   Overflow case: bcd = low DIGITS decimal digits of bin, overflow=1.
//   Digits above the value's magnitude are 0 (no blanking; display layer handles it).
//   rst mid-conversion: abort immediately, all outputs to reset values, no done pulse.
//   rst has priority over start on the same edge.
//   Arithmetic: working digits 4 bits each; after correction+shift each digit is 0..9.
// TESTING
//   1. WIDTH=16,DIGITS=5: bin=0, start 1 cycle -> busy 16 cycles, done at E0+16,
//      bcd=20'h00000, overflow=0.
//   2. WIDTH=16,DIGITS=5: bin=12345 -> bcd=20'h12345; bin=65535 -> bcd=20'h65535,
//      overflow=0.
//   3. WIDTH=8,DIGITS=2: bin=99 -> bcd=8'h99,ovf=0; bin=100 -> 8'h00,ovf=1;
//      bin=255 -> 8'h55,ovf=1.
//   4. WIDTH=6,DIGITS=2 exhaustive 0..63: bcd[3:0]==bin%10, bcd[7:4]==bin/10,
//      ovf=0, done exactly 6 cycles after each start.
//   5. Handshake: start held high continuously with bin changing -> conversions
//      every 17 cycles (WIDTH=16), each result equals bin captured at acceptance;
//      start pulses while busy produce nothing.
//   6. rst asserted 5 cycles into conversion of 4321 -> next cycle busy=0, done=0,
//      bcd=0, ovf=0; no done later; new start afterwards converts normally.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one input bit per clock,
// start/busy/done handshake, overflow when the value exceeds DIGITS decimal digits.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q;
    logic [WIDTH-1:0]    shift_q;
    logic [4*DIGITS-1:0] work_q;
    logic                acc_q;
    logic [CW-1:0]       count_q;

    logic [4*DIGITS-1:0] corr_d;
    logic [4*DIGITS-1:0] work_d;
    logic [WIDTH-1:0]    shift_d;
    logic                acc_d;

    // Add-3 correction on every working digit, all in parallel ahead of the shift.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_corr
            assign corr_d[4*gi +: 4] = (work_q[4*gi +: 4] >= 4'd5) ?
                                       (work_q[4*gi +: 4] + 4'd3) :
                                        work_q[4*gi +: 4];
        end
    endgenerate

    // Any bit carried out of the top digit means the value needs more digits.
    assign work_d  = {corr_d[4*DIGITS-2:0], shift_q[WIDTH-1]};
    assign shift_d = {shift_q[WIDTH-2:0], 1'b0};
    assign acc_d   = acc_q | corr_d[4*DIGITS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            work_q   <= '0;
            acc_q    <= 1'b0;
            count_q  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q <= bin;
                        work_q  <= '0;
                        acc_q   <= 1'b0;
                        count_q <= CW'(WIDTH);
                        busy    <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_q <= shift_d;
                    work_q  <= work_d;
                    acc_q   <= acc_d;
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        bcd      <= work_d;
                        overflow <= acc_d;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
